// File: rtl/gbsha_ttfir_pkg.sv
// Shared types and pin map for the TinyTapeout FIR host driver.
package gbsha_ttfir_pkg;
   typedef enum logic [1:0] {IDLE, RST, LOAD, RUN} state_e;
   typedef enum logic [1:0] {ARM, HIGH, WAIT} phase_e;

   // FIR tile io_in pin assignment
   localparam int IO_CLK   = 0;
   localparam int IO_RST   = 1;
   localparam int IO_X_LSB = 2;

   localparam int DEF_N_TAPS       = 4;
   localparam int DEF_BW_IN        = 6;
   localparam int DEF_BW_OUT       = 8;
   localparam int DEF_RESET_CYCLES = 2;
endpackage

// File: rtl/gbsha_ttfir_driver.sv
// Host-side initiator for the TinyTapeout FIR tile: generates the FIR clock and
// reset, shifts in the coefficients, streams samples and captures each result.
module gbsha_ttfir_driver
   import gbsha_ttfir_pkg::*;
#(
   parameter int N_TAPS       = DEF_N_TAPS,
   parameter int BW_in        = DEF_BW_IN,
   parameter int BW_out       = DEF_BW_OUT,
   parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic                    stop,
   input  logic [N_TAPS*BW_in-1:0] coef_in,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [BW_in-1:0]        s_data,
   output logic                    y_valid,
   output logic [BW_out-1:0]       y_data,
   output logic                    busy,
   output logic                    running,
   output logic [7:0]              fir_io_in,
   input  logic [7:0]              fir_io_out
);
   localparam int CNT_MAX = (RESET_CYCLES > N_TAPS) ? RESET_CYCLES : N_TAPS;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(N_TAPS - 1);

   state_e                    r_state, w_state_nxt;
   phase_e                    r_phase, w_phase_nxt;
   logic [CNT_W-1:0]          r_cnt, w_cnt_nxt;
   logic [N_TAPS*BW_in-1:0]   r_coef, w_coef_nxt;
   logic                      r_first, w_first_nxt;   // a RUN period has already been clocked
   logic                      r_fclk, w_fclk_nxt;
   logic                      r_frst, w_frst_nxt;
   logic [BW_in-1:0]          r_fdat, w_fdat_nxt;
   logic                      r_yv, w_yv_nxt;
   logic [BW_out-1:0]         r_yd, w_yd_nxt;
   logic                      r_busy, r_running;
   logic                      w_wait;

   // Sample acceptance window: RUN/WAIT with stop taking priority over s_valid
   assign w_wait  = (r_state == RUN) && (r_phase == WAIT);
   assign s_ready = w_wait && !stop;

   // Next-state logic; pin bits only change on the edge entering ARM so every
   // fir_clk rise sees one full clk of setup
   always_comb begin
      w_state_nxt = r_state;
      w_phase_nxt = r_phase;
      w_cnt_nxt   = r_cnt;
      w_coef_nxt  = r_coef;
      w_first_nxt = r_first;
      w_fclk_nxt  = r_fclk;
      w_frst_nxt  = r_frst;
      w_fdat_nxt  = r_fdat;
      w_yv_nxt    = 1'b0;
      w_yd_nxt    = r_yd;
      if (r_state == IDLE) begin
         w_fclk_nxt  = 1'b0;
         w_frst_nxt  = 1'b0;
         w_fdat_nxt  = '0;
         w_phase_nxt = ARM;
         if (start) begin
            w_coef_nxt  = coef_in;
            w_state_nxt = RST;
            w_cnt_nxt   = '0;
            w_frst_nxt  = 1'b1;
         end
      end else begin
         case (r_phase)
            ARM: begin
               w_fclk_nxt  = 1'b1;
               w_phase_nxt = HIGH;
            end
            HIGH: begin
               w_fclk_nxt  = 1'b0;
               w_phase_nxt = ARM;
               case (r_state)
                  RST: begin
                     w_cnt_nxt = r_cnt + 1'b1;
                     if (r_cnt == RST_LAST) begin
                        // first coefficient goes out oldest-first (coef[N_TAPS-1])
                        w_state_nxt = LOAD;
                        w_cnt_nxt   = '0;
                        w_frst_nxt  = 1'b0;
                        w_fdat_nxt  = r_coef[(N_TAPS-1)*BW_in +: BW_in];
                        w_coef_nxt  = r_coef << BW_in;
                     end
                  end
                  LOAD: begin
                     if (r_cnt == LOAD_LAST) begin
                        w_state_nxt = RUN;
                        w_phase_nxt = WAIT;
                        w_first_nxt = 1'b0;
                     end else begin
                        w_cnt_nxt  = r_cnt + 1'b1;
                        w_fdat_nxt = r_coef[(N_TAPS-1)*BW_in +: BW_in];
                        w_coef_nxt = r_coef << BW_in;
                     end
                  end
                  default: begin
                     // FIR sum is registered: the first RUN period has nothing valid
                     w_phase_nxt = WAIT;
                     w_first_nxt = 1'b1;
                     if (r_first) begin
                        w_yv_nxt = 1'b1;
                        w_yd_nxt = fir_io_out[BW_out-1:0];
                     end
                  end
               endcase
            end
            default: begin
               if (stop) begin
                  w_state_nxt = IDLE;
                  w_phase_nxt = ARM;
                  w_fdat_nxt  = '0;
               end else if (s_valid) begin
                  w_fdat_nxt  = s_data;
                  w_phase_nxt = ARM;
               end
            end
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_phase   <= ARM;
         r_cnt     <= '0;
         r_coef    <= '0;
         r_first   <= 1'b0;
         r_fclk    <= 1'b0;
         r_frst    <= 1'b0;
         r_fdat    <= '0;
         r_yv      <= 1'b0;
         r_yd      <= '0;
         r_busy    <= 1'b0;
         r_running <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_phase   <= w_phase_nxt;
         r_cnt     <= w_cnt_nxt;
         r_coef    <= w_coef_nxt;
         r_first   <= w_first_nxt;
         r_fclk    <= w_fclk_nxt;
         r_frst    <= w_frst_nxt;
         r_fdat    <= w_fdat_nxt;
         r_yv      <= w_yv_nxt;
         r_yd      <= w_yd_nxt;
         r_busy    <= (w_state_nxt != IDLE);
         r_running <= (w_state_nxt == RUN);
      end
   end

   // Pin assembly; unused upper io_in pins held low
   always_comb begin
      fir_io_in                      = '0;
      fir_io_in[IO_CLK]              = r_fclk;
      fir_io_in[IO_RST]              = r_frst;
      fir_io_in[IO_X_LSB +: BW_in]   = r_fdat;
   end

   assign y_valid = r_yv;
   assign y_data  = r_yd;
   assign busy    = r_busy;
   assign running = r_running;
endmodule
